// File: rtl/weight_fetch_ctrl.sv
// Weight fetch sequencer: streams one kernel of reads from the weight memory,
// captures the 1-cycle-latency data into a parallel bank and hands it off via valid/ack.
module weight_fetch_ctrl #(
    parameter int KERNEL_COUNT = 9,
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [ADDR_WIDTH-1:0]                base_addr,
    output logic                                 mem_rd_en,
    output logic [ADDR_WIDTH-1:0]                mem_rd_addr,
    input  logic [DATA_WIDTH:0]                  mem_weight,
    output logic [KERNEL_COUNT*DATA_WIDTH-1:0]   weights_out,
    output logic                                 weights_valid,
    input  logic                                 weights_ack,
    output logic                                 busy
);

    localparam int CW = $clog2(KERNEL_COUNT + 1);
    localparam logic [CW-1:0] K_CNT  = CW'(KERNEL_COUNT);
    localparam logic [CW-1:0] K_LAST = CW'(KERNEL_COUNT - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, READY} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_issue_cnt;
    logic [CW-1:0]   r_cap_idx;
    logic            r_cap_en;

    // The memory's extra top bit carries no weight information.
    logic            w_unused_top;
    assign w_unused_top = mem_weight[DATA_WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_issue_cnt   <= '0;
            r_cap_idx     <= '0;
            r_cap_en      <= 1'b0;
            mem_rd_en     <= 1'b0;
            mem_rd_addr   <= '0;
            weights_out   <= '0;
            weights_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            // Capture runs one cycle behind issue, independent of the state.
            r_cap_en <= mem_rd_en;
            if (r_cap_en) begin
                for (int k = 0; k < KERNEL_COUNT; k++) begin
                    if (r_cap_idx == CW'(k)) begin
                        weights_out[k*DATA_WIDTH +: DATA_WIDTH] <= mem_weight[DATA_WIDTH-1:0];
                    end
                end
                r_cap_idx <= r_cap_idx + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= base_addr;
                        r_issue_cnt <= CW'(1);
                        r_cap_idx   <= '0;
                        busy        <= 1'b1;
                        r_state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (r_issue_cnt < K_CNT) begin
                        mem_rd_addr <= mem_rd_addr + 1'b1;
                        r_issue_cnt <= r_issue_cnt + 1'b1;
                    end else begin
                        mem_rd_en <= 1'b0;
                        r_state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_cap_en && (r_cap_idx == K_LAST)) begin
                        weights_valid <= 1'b1;
                        r_state       <= READY;
                    end
                end
                READY: begin
                    if (weights_ack) begin
                        weights_valid <= 1'b0;
                        busy          <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: cycle-timeline model of one fetch plus directed and random stimulus.
`timescale 1ns/1ps
module tb_weight_fetch_ctrl;
    localparam int K  = 9;
    localparam int AW = 10;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              weights_ack = 1'b0;
    logic [AW-1:0]     base_addr = '0;
    logic              mem_rd_en;
    logic [AW-1:0]     mem_rd_addr;
    logic [DW:0]       mem_weight = '0;
    logic [K*DW-1:0]   weights_out;
    logic              weights_valid;
    logic              busy;

    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                rd_cnt = 0;
    logic [15:0]       salt = '0;

    always #5 clk = ~clk;

    weight_fetch_ctrl #(.KERNEL_COUNT(K), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_weight(mem_weight),
        .weights_out(weights_out), .weights_valid(weights_valid),
        .weights_ack(weights_ack), .busy(busy)
    );

    function automatic logic [DW:0] memf(input logic [AW-1:0] a, input logic [15:0] s);
        logic [15:0] v;
        v = 16'(32'(a) * 3) + s;
        return {1'b1, v};
    endfunction

    // Weight memory with one cycle read latency
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_en) begin
            mem_weight <= memf(mem_rd_addr, salt);
            rd_cnt     <= rd_cnt + 1;
        end
    end

    // Model: a fetch is a timeline of edges j = 0,1,2,... after the start edge.
    bit            m_active;
    int            m_j;
    logic [AW-1:0] m_base;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_w [K];

    initial begin
        logic [DW:0] t;
        m_active = 0; m_j = 0; m_base = '0; m_addr = '0;
        for (int k = 0; k < K; k++) m_w[k] = '0;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_active = 0; m_j = 0; m_addr = '0;
                for (int k = 0; k < K; k++) m_w[k] = '0;
            end else if (m_active) begin
                if (m_j >= K + 1 && weights_ack) begin
                    m_active = 0;
                end else begin
                    m_j++;
                    if (m_j <= K - 1) m_addr = m_base + AW'(m_j);
                    if (m_j >= 2 && m_j <= K + 1) begin
                        t = memf(m_base + AW'(m_j - 2), salt);
                        m_w[m_j-2] = t[DW-1:0];
                    end
                end
            end else if (start) begin
                m_active = 1; m_j = 0; m_base = base_addr; m_addr = base_addr;
            end
        end
    end

    task automatic chk(input string name, input logic [K*DW-1:0] act, input logic [K*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    initial begin
        logic [K*DW-1:0] exp_pk;
        logic            exp_rd;
        forever begin
            @(negedge clk);
            exp_rd = m_active && (m_j <= K - 1);
            for (int k = 0; k < K; k++) exp_pk[k*DW +: DW] = m_w[k];
            chk("rd_en", {{(K*DW-1){1'b0}}, mem_rd_en}, {{(K*DW-1){1'b0}}, exp_rd});
            if (exp_rd) chk("rd_addr", {{(K*DW-AW){1'b0}}, mem_rd_addr}, {{(K*DW-AW){1'b0}}, m_addr});
            chk("valid", {{(K*DW-1){1'b0}}, weights_valid},
                {{(K*DW-1){1'b0}}, (m_active && m_j >= K + 1)});
            chk("busy", {{(K*DW-1){1'b0}}, busy}, {{(K*DW-1){1'b0}}, m_active});
            chk("weights_out", weights_out, exp_pk);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input int budget);
        int c;
        c = 0;
        while (!weights_valid && c < budget) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (!weights_valid) begin
            errors++;
            $display("FAIL wait_valid: valid not seen within %0d cycles", budget);
        end
    endtask

    function automatic logic [K*DW-1:0] sl(input int k);
        return {{(K*DW-DW){1'b0}}, weights_out[k*DW +: DW]};
    endfunction

    initial begin
        int cs, rb, vcnt;
        step(3);
        reset = 1'b1;

        // Idle after reset
        step(20);
        chk("idle_busy", {{(K*DW-1){1'b0}}, busy}, '0);
        chk("idle_wout", weights_out, '0);
        chk("idle_addr", {{(K*DW-AW){1'b0}}, mem_rd_addr}, '0);

        // Basic fetch from 18 with spurious starts in FETCH and READY
        rb = rd_cnt; cs = cyc;
        base_addr = 18; start = 1'b1; step(1); start = 1'b0;
        step(3); start = 1'b1; step(1); start = 1'b0;
        wait_valid(30);
        chk("latency", (K*DW)'(cyc - cs - 1), (K*DW)'(10));
        chk("slice0_18", sl(0), (K*DW)'(54));
        chk("slice8_18", sl(8), (K*DW)'(78));
        step(2); start = 1'b1; step(1); start = 1'b0; step(1);
        weights_ack = 1'b1; start = 1'b1; step(1); weights_ack = 1'b0; start = 1'b0;
        chk("ack_valid", {{(K*DW-1){1'b0}}, weights_valid}, '0);
        chk("ack_busy", {{(K*DW-1){1'b0}}, busy}, '0);
        chk("ack_hold", sl(0), (K*DW)'(54));
        step(5);
        chk("reads_18", (K*DW)'(rd_cnt - rb), (K*DW)'(9));

        // Address wrap
        base_addr = 1020; start = 1'b1; step(1); start = 1'b0;
        wait_valid(30);
        chk("wrap_s3", sl(3), (K*DW)'(3069));
        chk("wrap_s4", sl(4), (K*DW)'(0));
        chk("wrap_s8", sl(8), (K*DW)'(12));
        weights_ack = 1'b1; step(1); weights_ack = 1'b0;
        step(2);

        // Back-to-back with start and ack held high
        base_addr = 0; start = 1'b1; weights_ack = 1'b1; vcnt = 0;
        repeat (48) begin
            @(negedge clk);
            if (weights_valid) begin
                vcnt++;
                base_addr = (base_addr == 0) ? AW'(100) : AW'(0);
            end
        end
        start = 1'b0; weights_ack = 1'b0;
        chk("b2b_count", (K*DW)'(vcnt), (K*DW)'(4));
        step(15);

        // Asynchronous reset mid-fetch
        base_addr = 50; start = 1'b1; step(1); start = 1'b0; step(3);
        #2 reset = 1'b0;
        #1;
        chk("rst_rd_en", {{(K*DW-1){1'b0}}, mem_rd_en}, '0);
        chk("rst_busy", {{(K*DW-1){1'b0}}, busy}, '0);
        chk("rst_wout", weights_out, '0);
        @(negedge clk);
        reset = 1'b1;
        rb = rd_cnt;
        base_addr = 200; start = 1'b1; step(1); start = 1'b0;
        wait_valid(30);
        chk("post_rst_s0", sl(0), (K*DW)'(600));
        chk("post_rst_s8", sl(8), (K*DW)'(624));
        chk("post_rst_reads", (K*DW)'(rd_cnt - rb), (K*DW)'(9));
        weights_ack = 1'b1; step(1); weights_ack = 1'b0;
        step(2);

        // Randomized traffic
        salt = 16'($urandom);
        repeat (400) begin
            start       = ($urandom_range(0, 3) == 0);
            weights_ack = ($urandom_range(0, 2) == 0);
            base_addr   = AW'($urandom);
            step(1);
        end
        start = 1'b0; weights_ack = 1'b0;
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
